// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receiver bus: raw line inputs, receive enable, FIFO read side
// and per-frame status pulses.
interface ps2_rx_fifo_if;
    logic       ps2d;
    logic       ps2c;
    logic       rx_enable;
    logic       rd_en;
    logic [7:0] dout;
    logic       rx_valid;
    logic       fifo_full;
    logic       rx_done_Tick;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    modport master (
        output ps2d, ps2c, rx_enable, rd_en,
        input  dout, rx_valid, fifo_full,
        input  rx_done_Tick, frame_err, parity_err, overrun_err
    );

    modport slave (
        input  ps2d, ps2c, rx_enable, rd_en,
        output dout, rx_valid, fifo_full,
        output rx_done_Tick, frame_err, parity_err, overrun_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter and byte FIFO.
// Define PS2_PARITY_CHECK_EN to enforce odd parity on received frames.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          Clock,
    input  logic          Reset,
    ps2_rx_fifo_if.slave  bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

    // ps2c filter
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q;
    logic                  fclk_d;
    logic                  fall_edge;

    always_comb begin
        fclk_d = fclk_q;
        if (&filt_q)
            fclk_d = 1'b1;
        else if (~|filt_q)
            fclk_d = 1'b0;
        fall_edge = fclk_q & ~fclk_d;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            filt_q <= '0;
            fclk_q <= 1'b0;
        end else begin
            filt_q <= {bus.ps2c, filt_q[FILTER_LEN-1:1]};
            fclk_q <= fclk_d;
        end
    end

    // receive FSM
    state_t         state_q, state_d;
    logic [3:0]     bit_q, bit_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [9:0]     frame_q, frame_d;

    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [7:0]     mem [FIFO_DEPTH];

    logic full;
    logic not_empty;
    logic rd_go;
    logic wr_go;
    logic done_p;
    logic ferr_p;
    logic ovr_p;
`ifdef PS2_PARITY_CHECK_EN
    logic perr_p;
`endif

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign rd_go     = bus.rd_en & not_empty;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tmo_d   = tmo_q;
        frame_d = frame_q;
        wr_go   = 1'b0;
        done_p  = 1'b0;
        ferr_p  = 1'b0;
        ovr_p   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_p  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    if (bus.ps2d) begin
                        ferr_p = 1'b1;
                    end else if (bus.rx_enable) begin
                        state_d = DATA;
                        bit_d   = '0;
                        tmo_d   = '0;
                    end
                end
            end
            DATA: begin
                if (fall_edge) begin
                    frame_d = {bus.ps2d, frame_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    tmo_d   = '0;
                    if (bit_q == 4'd9)
                        state_d = CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // line stalled mid-frame: drop it
                    ferr_p  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!frame_q[9])
                    ferr_p = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                else if (!(^frame_q[8:0]))
                    perr_p = 1'b1;
`endif
                else if (full && !rd_go)
                    ovr_p = 1'b1;
                else begin
                    wr_go  = 1'b1;
                    done_p = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tmo_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tmo_q   <= tmo_d;
            frame_q <= frame_d;
        end
    end

    // byte FIFO, first-word fall-through
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_go)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_go)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_go && !rd_go)
                cnt_q <= cnt_q + CW'(1);
            else if (!wr_go && rd_go)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_go)
            mem[wr_ptr_q] <= frame_q[7:0];
    end

    assign bus.dout         = not_empty ? mem[rd_ptr_q] : 8'h00;
    assign bus.rx_valid     = not_empty;
    assign bus.fifo_full    = full;
    assign bus.rx_done_Tick = done_p;
    assign bus.frame_err    = ferr_p;
    assign bus.overrun_err  = ovr_p;
`ifdef PS2_PARITY_CHECK_EN
    assign bus.parity_err   = perr_p;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, event and
// read-data queues checked by a negedge monitor.
module tb_ps2_rx_fifo;

    localparam int FL  = 8;
    localparam int FD  = 4;
    localparam int TMO = 300;
    localparam int H   = 20;

    localparam logic [3:0] EV_DONE = 4'b0001;
    localparam logic [3:0] EV_FERR = 4'b0010;
    localparam logic [3:0] EV_PERR = 4'b0100;
    localparam logic [3:0] EV_OVR  = 4'b1000;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .FILTER_LEN     (FL),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_ev [$];
    logic [7:0] exp_rd [$];

    // monitor: every status pulse and every accepted read is scored
    always @(negedge Clock) begin
        logic [3:0] ev;
        logic [3:0] e;
        logic [7:0] d;
        if (Reset === 1'b0) begin
            ev = {bus.overrun_err, bus.parity_err,
                  bus.frame_err, bus.rx_done_Tick};
            if (ev != 4'b0) begin
                total++;
                if (exp_ev.size() == 0) begin
                    bad++;
                    $display("FAIL event: got %b required none", ev);
                end else begin
                    e = exp_ev.pop_front();
                    if (ev !== e) begin
                        bad++;
                        $display("FAIL event: got %b required %b", ev, e);
                    end
                end
            end
            if (bus.rd_en && bus.rx_valid) begin
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL read: got %h required no read", bus.dout);
                end else begin
                    d = exp_rd.pop_front();
                    if (bus.dout !== d) begin
                        bad++;
                        $display("FAIL read: got %h required %h", bus.dout, d);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    function automatic logic [10:0] frm(input logic [7:0] data,
                                        input logic par, input logic stop);
        return {stop, par, data, 1'b0};
    endfunction

    task automatic send(input logic [10:0] bits, input int nb,
                        input int drop_at);
        for (int i = 0; i < nb; i++) begin
            if (i == drop_at)
                bus.rx_enable = 1'b0;
            bus.ps2d = bits[i];
            cyc(H);
            bus.ps2c = 1'b0;
            cyc(H);
            bus.ps2c = 1'b1;
        end
        bus.ps2d = 1'b1;
        cyc(3 * H);
        bus.rx_enable = 1'b1;
    endtask

    task automatic wait_ev(input string name);
        int n = 0;
        while (exp_ev.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        total++;
        if (exp_ev.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d events missing, required 0",
                     name, exp_ev.size());
            exp_ev.delete();
        end
    endtask

    task automatic rd(input logic [7:0] e);
        exp_rd.push_back(e);
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        cyc(1);
    endtask

    function automatic logic [12:0] outs();
        return {bus.dout, bus.rx_valid, bus.fifo_full, bus.rx_done_Tick,
                bus.frame_err, bus.parity_err | bus.overrun_err};
    endfunction

    initial begin
        bus.ps2d      = 1'b1;
        bus.ps2c      = 1'b1;
        bus.rx_enable = 1'b1;
        bus.rd_en     = 1'b0;
        Reset         = 1'b1;
        cyc(3);
        check("reset_outs", 32'(outs()), 32'h0);
        Reset = 1'b0;
        cyc(2 * FL + 5);
        check("idle_valid", 32'(bus.rx_valid), 32'h0);

        // good frame 0x1C
        exp_ev.push_back(EV_DONE);
        send(frm(8'h1C, 1'b0, 1'b1), 11, 99);
        wait_ev("t1c");
        check("t1c_dout", 32'(bus.dout), 32'h1C);
        check("t1c_valid", 32'(bus.rx_valid), 32'h1);
        rd(8'h1C);
        check("t1c_empty", 32'(bus.rx_valid), 32'h0);
        check("t1c_dout0", 32'(bus.dout), 32'h00);

        // read on empty FIFO is ignored
        bus.rd_en = 1'b1;
        cyc(2);
        bus.rd_en = 1'b0;
        cyc(1);
        check("rd_empty", 32'(bus.rx_valid), 32'h0);

        // bad parity on 0x1C
`ifdef PS2_PARITY_CHECK_EN
        exp_ev.push_back(EV_PERR);
        send(frm(8'h1C, 1'b1, 1'b1), 11, 99);
        wait_ev("par");
        check("par_valid", 32'(bus.rx_valid), 32'h0);
`else
        exp_ev.push_back(EV_DONE);
        send(frm(8'h1C, 1'b1, 1'b1), 11, 99);
        wait_ev("par");
        check("par_dout", 32'(bus.dout), 32'h1C);
        rd(8'h1C);
`endif

        // bad stop bit, then 0xF0 with rx_enable dropped mid-frame
        exp_ev.push_back(EV_FERR);
        send(frm(8'h5A, 1'b1, 1'b0), 11, 99);
        wait_ev("stop");
        check("stop_valid", 32'(bus.rx_valid), 32'h0);
        exp_ev.push_back(EV_DONE);
        send(frm(8'hF0, 1'b1, 1'b1), 11, 4);
        wait_ev("f0");
        check("f0_dout", 32'(bus.dout), 32'hF0);
        rd(8'hF0);

        // timeout after 5 bits
        exp_ev.push_back(EV_FERR);
        send(frm(8'h29, 1'b0, 1'b1), 5, 99);
        cyc(TMO + 50);
        wait_ev("tmo");
        check("tmo_valid", 32'(bus.rx_valid), 32'h0);
        exp_ev.push_back(EV_DONE);
        send(frm(8'h29, 1'b0, 1'b1), 11, 99);
        wait_ev("29");
        check("29_dout", 32'(bus.dout), 32'h29);
        rd(8'h29);

        // fill and overrun
        exp_ev.push_back(EV_DONE);
        send(frm(8'h11, 1'b1, 1'b1), 11, 99);
        exp_ev.push_back(EV_DONE);
        send(frm(8'h22, 1'b1, 1'b1), 11, 99);
        exp_ev.push_back(EV_DONE);
        send(frm(8'h33, 1'b1, 1'b1), 11, 99);
        check("full3", 32'(bus.fifo_full), 32'h0);
        exp_ev.push_back(EV_DONE);
        send(frm(8'h44, 1'b1, 1'b1), 11, 99);
        wait_ev("fill");
        check("full4", 32'(bus.fifo_full), 32'h1);
        exp_ev.push_back(EV_OVR);
        send(frm(8'h55, 1'b1, 1'b1), 11, 99);
        wait_ev("ovr");
        check("full5", 32'(bus.fifo_full), 32'h1);
        rd(8'h11);
        check("full_rd", 32'(bus.fifo_full), 32'h0);
        rd(8'h22);
        rd(8'h33);
        rd(8'h44);
        check("drained", 32'(bus.rx_valid), 32'h0);

        // short low glitch on idle ps2c
        bus.ps2c = 1'b0;
        cyc(3);
        bus.ps2c = 1'b1;
        cyc(30);
        check("glitch", 32'(bus.rx_valid), 32'h0);

        // reset mid-frame
        send(frm(8'h33, 1'b1, 1'b1), 4, 99);
        Reset = 1'b1;
        cyc(2);
        check("rst_mid", 32'(outs()), 32'h0);
        Reset = 1'b0;
        cyc(2 * FL + 5);
        exp_ev.push_back(EV_DONE);
        send(frm(8'h33, 1'b1, 1'b1), 11, 99);
        wait_ev("post_rst");
        check("post_rst_dout", 32'(bus.dout), 32'h33);
        rd(8'h33);

        cyc(5);
        check("ev_left", 32'(exp_ev.size()), 32'h0);
        check("rd_left", 32'(exp_rd.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
